// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types, constants and sizing helpers for the truth-table sequencer
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DEF_N_IN   = 2;
    localparam int DEF_SETTLE = 1;
    localparam int NUM_VEC    = 2 ** DEF_N_IN;

    // number of input vectors swept for a gate with n inputs
    function automatic int num_vec(input int n);
        return 1 << n;
    endfunction

    // settle counter width; a single bit is kept even when SETTLE is 1
    function automatic int cnt_width(input int settle);
        return (settle <= 2) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/gate_truth_table_sequencer_decoder.sv
// rtl/gate_truth_table_sequencer_decoder.sv - n-to-2^n one-hot decoder with enable
module decoder_n_to_2n #(
    parameter int N = 2
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [(1<<N)-1:0] onehot
);

    // single asserted bit at position sel while enabled
    always_comb begin
        onehot      = '0;
        onehot[sel] = en;
    end

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// rtl/gate_truth_table_sequencer.sv - sweeps gate input vectors, captures and checks the truth table (optional MISMATCH_ABORT_EN)
module gate_truth_table_sequencer
    import gate_seq_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [(1<<N_IN)-1:0]    exp_table,
    input  logic                    gate_in,
    output logic [N_IN-1:0]         vec_out,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_IN)-1:0]    table_out,
    output logic                    pass,
    output logic [N_IN-1:0]         fail_vec
);

    localparam int NV = num_vec(N_IN);
    localparam int CW = cnt_width(SETTLE);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NV-1:0]   table_q, table_d;
    logic [NV-1:0]   exp_q, exp_d;
    logic            pass_q, pass_d;
    logic [NV-1:0]   wr_onehot;
    logic            sample_en;

`ifdef MISMATCH_ABORT_EN
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;
`endif

    assign sample_en = (state_q == SAMPLE);

    decoder_n_to_2n #(.N(N_IN)) u_wr_dec (
        .sel    (vec_q),
        .en     (sample_en),
        .onehot (wr_onehot)
    );

    // next-state and datapath updates for the sweep
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
`ifdef MISMATCH_ABORT_EN
        fail_vec_d = fail_vec_q;
`endif
        case (state_q)
            IDLE: begin
                vec_d = '0;
                if (start) begin
                    exp_d   = exp_table;
                    table_d = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
`ifdef MISMATCH_ABORT_EN
                    fail_vec_d = '0;
`endif
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                table_d = (table_q & ~wr_onehot) | (wr_onehot & {NV{gate_in}});
`ifdef MISMATCH_ABORT_EN
                if (gate_in != exp_q[vec_q]) begin
                    fail_vec_d = vec_q;
                    pass_d     = 1'b0;
                    state_d    = DONE;
                end else
`endif
                if (vec_q == VEC_LAST) begin
                    pass_d  = (table_d == exp_q);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = DRIVE;
                end
            end
            DONE: begin
                vec_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
`ifdef MISMATCH_ABORT_EN
            fail_vec_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
`ifdef MISMATCH_ABORT_EN
            fail_vec_q <= fail_vec_d;
`endif
        end
    end

    assign vec_out   = vec_q;
    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign table_out = table_q;
    assign pass      = pass_q;
`ifdef MISMATCH_ABORT_EN
    assign fail_vec  = fail_vec_q;
`else
    assign fail_vec  = '0;
`endif

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// tb/tb_gate_truth_table_sequencer.sv - self-checking bench for gate_truth_table_sequencer
module tb_gate_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [3:0] exp_a, gtab_a;
    logic [7:0] exp_b, gtab_b;

    logic [1:0] vec_out_a;
    logic       busy_a, done_a, pass_a, gate_in_a;
    logic [3:0] table_out_a;
    logic [1:0] fail_vec_a;

    logic [2:0] vec_out_b;
    logic       busy_b, done_b, pass_b, gate_in_b;
    logic [7:0] table_out_b;
    logic [2:0] fail_vec_b;

    assign gate_in_a = gtab_a[vec_out_a];
    assign gate_in_b = gtab_b[vec_out_b];

    gate_truth_table_sequencer #(.N_IN(2), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .exp_table(exp_a), .gate_in(gate_in_a),
        .vec_out(vec_out_a), .busy(busy_a), .done(done_a), .table_out(table_out_a),
        .pass(pass_a), .fail_vec(fail_vec_a)
    );

    gate_truth_table_sequencer #(.N_IN(3), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .exp_table(exp_b), .gate_in(gate_in_b),
        .vec_out(vec_out_b), .busy(busy_b), .done(done_b), .table_out(table_out_b),
        .pass(pass_b), .fail_vec(fail_vec_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One sweep on instance inst (0: N_IN=2/SETTLE=1, 1: N_IN=3/SETTLE=3), checked cycle by cycle
    task automatic sweep(input int inst, input logic [7:0] gt, input logic [7:0] ex, input bit noise);
        int nv, hold, m, last_vec, last_i;
        logic [7:0] ref_tab, ex_m;
        logic ref_pass;
        logic [31:0] o_vec, o_tab, o_fail;
        logic o_busy, o_done, o_pass;
        nv   = (inst == 0) ? 4 : 8;
        hold = (inst == 0) ? 2 : 4;
        ex_m = ex & 8'((1 << nv) - 1);
        m = -1;
        for (int v = 0; v < nv; v++) if (m < 0 && gt[v] != ex_m[v]) m = v;
        ref_pass = (m < 0);
`ifdef MISMATCH_ABORT_EN
        last_vec = (m < 0) ? nv - 1 : m;
`else
        last_vec = nv - 1;
`endif
        ref_tab = '0;
        for (int v = 0; v <= last_vec; v++) ref_tab[v] = gt[v];
        last_i = (last_vec + 1) * hold;

        if (inst == 0) begin gtab_a = gt[3:0]; exp_a = ex[3:0]; start_a = 1'b1; end
        else           begin gtab_b = gt;      exp_b = ex;      start_b = 1'b1; end
        tick;
        for (int i = 0; i <= last_i; i++) begin
            if (inst == 0) start_a = noise ? 1'($urandom % 2) : 1'b0;
            else           start_b = noise ? 1'($urandom % 2) : 1'b0;
            if (inst == 0) begin
                o_vec = 32'(vec_out_a); o_tab = 32'(table_out_a); o_fail = 32'(fail_vec_a);
                o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            end else begin
                o_vec = 32'(vec_out_b); o_tab = 32'(table_out_b); o_fail = 32'(fail_vec_b);
                o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            end
            if (i < last_i) begin
                chk($sformatf("vec_i%0d", i), o_vec, 32'(i / hold));
                chk($sformatf("busy_i%0d", i), 32'(o_busy), 32'd1);
                chk($sformatf("done_early_i%0d", i), 32'(o_done), 32'd0);
            end else begin
                chk("done_pulse", 32'(o_done), 32'd1);
                chk("busy_in_done", 32'(o_busy), 32'd0);
                chk("table_out", o_tab, 32'(ref_tab));
                chk("pass", 32'(o_pass), 32'(ref_pass));
`ifdef MISMATCH_ABORT_EN
                chk("fail_vec", o_fail, (m < 0) ? 32'd0 : 32'(m));
`else
                chk("fail_vec", o_fail, 32'd0);
`endif
            end
            tick;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (inst == 0) begin
                o_vec = 32'(vec_out_a); o_tab = 32'(table_out_a);
                o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            end else begin
                o_vec = 32'(vec_out_b); o_tab = 32'(table_out_b);
                o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            end
            chk("idle_done", 32'(o_done), 32'd0);
            chk("idle_busy", 32'(o_busy), 32'd0);
            chk("idle_vec", o_vec, 32'd0);
            chk("hold_table", o_tab, 32'(ref_tab));
            chk("hold_pass", 32'(o_pass), 32'(ref_pass));
            tick;
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        exp_a = '0; gtab_a = '0; exp_b = '0; gtab_b = '0;
        tick; tick;
        chk("rst_vec_a", 32'(vec_out_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_table_a", 32'(table_out_a), 32'd0);
        chk("rst_pass_a", 32'(pass_a), 32'd0);
        chk("rst_fail_a", 32'(fail_vec_a), 32'd0);
        chk("rst_table_b", 32'(table_out_b), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        tick;

        // AND, OR, OR with wrong expectation, AND with start noise during the sweep
        sweep(0, 8'b1000, 8'b1000, 1'b0);
        sweep(0, 8'b1110, 8'b1110, 1'b0);
        sweep(0, 8'b1110, 8'b0110, 1'b0);
        sweep(0, 8'b1000, 8'b1000, 1'b1);
        sweep(0, 8'b1000, 8'b1010, 1'b0);

        // XOR of the two LSBs on the 3-input, settle-3 instance
        sweep(1, 8'b0110_0110, 8'b0110_0110, 1'b0);

        // randomized gate functions and expectations
        for (int r = 0; r < 6; r++) begin
            logic [7:0] g;
            g = 8'($urandom);
            sweep(0, g, ($urandom % 2 == 0) ? g : 8'($urandom), 1'($urandom % 2));
        end
        for (int r = 0; r < 3; r++) begin
            logic [7:0] g;
            g = 8'($urandom);
            sweep(1, g, ($urandom % 2 == 0) ? g : 8'($urandom), 1'b0);
        end

        // reset in cycle 5 of a sweep
        gtab_a = 4'b1111; exp_a = 4'b1111; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_table", 32'(table_out_a), 32'd0);
        chk("midrst_vec", 32'(vec_out_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        for (int j = 0; j < 10; j++) begin
            chk("midrst_no_done", 32'(done_a), 32'd0);
            tick;
        end

        // reset together with start
        rst = 1'b1; start_a = 1'b1;
        tick;
        rst = 1'b0; start_a = 1'b0;
        chk("rststart_busy", 32'(busy_a), 32'd0);
        tick;
        chk("rststart_busy2", 32'(busy_a), 32'd0);
        chk("rststart_done", 32'(done_a), 32'd0);
        chk("rststart_vec", 32'(vec_out_a), 32'd0);

        // normal sweep still works after resets
        sweep(0, 8'b0001, 8'b0001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
